// File: rtl/regfile_scanner.sv
`timescale 1ns/1ps
// Walks ra from lo to hi (wrapping) and streams each (address, data) pair out on a valid/ready port.
// Latency: first word valid one cycle after start is taken; each word costs FETCH+SEND, so 2 cycles/word with out_ready high.
// Backpressure: out_valid/out_addr/out_data hold until out_ready handshakes; abort drops the in-flight word.
module regfile_scanner #(
    parameter int M = 3,
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [M:0]   lo,
    input  logic [M:0]   hi,
    input  logic         abort,
    output logic [M:0]   ra,
    input  logic [N:0]   rd,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M:0]   out_addr,
    output logic [N:0]   out_data,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_SEND  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     state, state_nxt;
    logic [M:0] last, last_nxt;
    logic [M:0] ra_nxt;
    logic       out_valid_nxt;
    logic [M:0] out_addr_nxt;
    logic [N:0] out_data_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ra        <= '0;
            last      <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
        end else begin
            state     <= state_nxt;
            ra        <= ra_nxt;
            last      <= last_nxt;
            out_valid <= out_valid_nxt;
            out_addr  <= out_addr_nxt;
            out_data  <= out_data_nxt;
        end
    end

    // abort takes priority over every other transition, including a same-cycle handshake
    always_comb begin
        state_nxt     = state;
        ra_nxt        = ra;
        last_nxt      = last;
        out_valid_nxt = out_valid;
        out_addr_nxt  = out_addr;
        out_data_nxt  = out_data;
        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    ra_nxt    = lo;
                    last_nxt  = hi;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else begin
                    out_data_nxt  = rd;
                    out_addr_nxt  = ra;
                    out_valid_nxt = 1'b1;
                    state_nxt     = S_SEND;
                end
            end
            S_SEND: begin
                if (abort) begin
                    out_valid_nxt = 1'b0;
                    state_nxt     = S_IDLE;
                end else if (out_valid && out_ready) begin
                    out_valid_nxt = 1'b0;
                    if (ra == last) begin
                        state_nxt = S_DONE;
                    end else begin
                        // carry out of the top bit is dropped, giving the wrap to address 0
                        ra_nxt    = ra + (M+1)'(1);
                        state_nxt = S_FETCH;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy = (state == S_FETCH) || (state == S_SEND);
    assign done = (state == S_DONE);

endmodule
